// File: rtl/keypad_scan.sv
// Multi-pad keypad scanner: per-key debounce, CPU-written key select, and
// active-low EF flags per pad, with optional latched-press (sticky) behaviour.
module keypad_scan #(
  parameter int unsigned NUM_PADS   = 2,
  parameter int unsigned KEYS       = 10,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned DB_SAMPLES = 4,
  parameter int unsigned SEL_PORT   = 2,
  parameter int unsigned STICKY     = 0
) (
  input  logic                     clk_sys,
  input  logic                     resetq,
  input  logic [NUM_PADS*KEYS-1:0] key_raw,
  input  logic                     io_out,
  input  logic [2:0]               io_n,
  input  logic [7:0]               io_dout,
  output logic [NUM_PADS-1:0]      ef_n,
  output logic                     any_n,
  output logic [3:0]               key_sel
);

  localparam int unsigned NumKeys = NUM_PADS * KEYS;
  localparam int unsigned PsW     = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  // Asynchronous assertion, synchronous release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk_sys or negedge resetq) begin
    if (!resetq) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [PsW-1:0]                        presc_q, presc_d;
  logic                                  tick;
  logic [NumKeys-1:0]                    sync1_q, sync2_q;
  logic [NumKeys-1:0][DB_SAMPLES-1:0]    samp_q, samp_d;
  logic [NumKeys-1:0]                    deb_q, deb_d;
  logic [NumKeys-1:0]                    sticky_q, sticky_d;
  logic [NumKeys-1:0]                    held;
  logic [3:0]                            key_sel_q, key_sel_d;
  logic [NUM_PADS-1:0]                   ef_n_q, ef_n_d;
  logic                                  any_n_q, any_n_d;
  logic                                  sel_wr;
  logic                                  hit;
  logic [3:0]                            unused_dout;

  assign unused_dout = io_dout[7:4];

  always_comb begin
    tick    = (presc_q == PsW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PsW'(1);
    sel_wr  = io_out && (io_n == 3'(SEL_PORT));
    key_sel_d = sel_wr ? io_dout[3:0] : key_sel_q;

    samp_d   = samp_q;
    deb_d    = deb_q;
    sticky_d = '0;
    for (int unsigned k = 0; k < NumKeys; k++) begin
      if (tick) samp_d[k] = {samp_q[k][DB_SAMPLES-2:0], sync2_q[k]};
      if (&samp_q[k])       deb_d[k] = 1'b1;
      else if (~|samp_q[k]) deb_d[k] = 1'b0;
      if (STICKY != 0) begin
        sticky_d[k] = sticky_q[k];
        if (sel_wr && ({28'd0, key_sel_q} == (k % KEYS))) sticky_d[k] = 1'b0;
        // Set wins over a same-cycle clear.
        if (deb_d[k] && !deb_q[k]) sticky_d[k] = 1'b1;
      end
    end

    held = deb_q | sticky_q;
    ef_n_d = '1;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      hit = 1'b0;
      // Selects at or beyond KEYS match nothing, so the flag stays inactive.
      for (int unsigned k = 0; k < KEYS; k++) begin
        if (key_sel_q == 4'(k)) hit = held[p*KEYS + k];
      end
      ef_n_d[p] = ~hit;
    end
    any_n_d = ~|deb_q;
  end

  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      presc_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      deb_q     <= '0;
      sticky_q  <= '0;
      key_sel_q <= 4'd0;
      ef_n_q    <= '1;
      any_n_q   <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      deb_q     <= deb_d;
      sticky_q  <= sticky_d;
      key_sel_q <= key_sel_d;
      ef_n_q    <= ef_n_d;
      any_n_q   <= any_n_d;
    end
  end

  assign ef_n    = ef_n_q;
  assign any_n   = any_n_q;
  assign key_sel = key_sel_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a direct-mode and a sticky-mode instance
// share stimulus; expectations are queued with stimulus and popped at sampling.
module tb_keypad_scan;

  localparam int unsigned NP = 2;
  localparam int unsigned K  = 10;
  localparam int unsigned PS = 4;
  localparam int unsigned DB = 4;

  logic              clk_sys = 1'b0;
  logic              resetq;
  logic [NP*K-1:0]   key_raw;
  logic              io_out;
  logic [2:0]        io_n;
  logic [7:0]        io_dout;
  logic [NP-1:0]     ef_n, ef_n_s;
  logic              any_n, any_n_s;
  logic [3:0]        key_sel, key_sel_s;

  always #5 clk_sys = ~clk_sys;

  keypad_scan #(
    .NUM_PADS(NP), .KEYS(K), .PRESCALE(PS), .DB_SAMPLES(DB), .SEL_PORT(2), .STICKY(0)
  ) dut (
    .clk_sys(clk_sys), .resetq(resetq), .key_raw(key_raw), .io_out(io_out), .io_n(io_n),
    .io_dout(io_dout), .ef_n(ef_n), .any_n(any_n), .key_sel(key_sel)
  );

  keypad_scan #(
    .NUM_PADS(NP), .KEYS(K), .PRESCALE(PS), .DB_SAMPLES(DB), .SEL_PORT(2), .STICKY(1)
  ) dut_s (
    .clk_sys(clk_sys), .resetq(resetq), .key_raw(key_raw), .io_out(io_out), .io_n(io_n),
    .io_dout(io_dout), .ef_n(ef_n_s), .any_n(any_n_s), .key_sel(key_sel_s)
  );

  localparam int ObsEf = 0, ObsAny = 1, ObsSel = 2, ObsEfS = 3, ObsAnyS = 4, ObsSelS = 5;

  typedef struct {
    string      tag;
    int         what;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] observe(input int what);
    case (what)
      ObsEf:   return {6'd0, ef_n};
      ObsAny:  return {7'd0, any_n};
      ObsSel:  return {4'd0, key_sel};
      ObsEfS:  return {6'd0, ef_n_s};
      ObsAnyS: return {7'd0, any_n_s};
      ObsSelS: return {4'd0, key_sel_s};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int what, input logic [7:0] exp);
    exp_t e;
    e.tag = tag; e.what = what; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    @(negedge clk_sys);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.what), e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic sel_write(input logic [7:0] data, input logic [2:0] port);
    io_out = 1'b1; io_n = port; io_dout = data;
    cyc(1);
    io_out = 1'b0; io_n = 3'd0;
    cyc(1);
  endtask

  // Bounded wait for ef_n[pad] (direct instance) to reach val.
  task automatic wait_ef(input string tag, input int pad, input logic val, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (ef_n[pad] === val) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {7'd0, seen}, 8'd1);
    cyc(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    resetq = 1'b0; key_raw = '1; io_out = 1'b0; io_n = 3'd0; io_dout = 8'd0;

    // Reset with every key held.
    cyc(3);
    expect_out("rst_ef", ObsEf, 8'h03);
    expect_out("rst_any", ObsAny, 8'h01);
    expect_out("rst_sel", ObsSel, 8'h00);
    expect_out("rst_ef_s", ObsEfS, 8'h03);
    expect_out("rst_any_s", ObsAnyS, 8'h01);
    drain();
    key_raw = '0;
    cyc(2);
    resetq = 1'b1;
    cyc(8);

    // Debounce pad1 key5.
    sel_write(8'h05, 3'd2);
    expect_out("sel5", ObsSel, 8'h05);
    expect_out("sel5_ef", ObsEf, 8'h03);
    drain();
    key_raw[1*K + 5] = 1'b1;
    wait_ef("deb_press_lat", 1, 1'b0, 4*PS + 4);
    expect_out("deb_press_ef", ObsEf, 8'h01);
    expect_out("deb_press_any", ObsAny, 8'h00);
    drain();
    key_raw[1*K + 5] = 1'b0;
    cyc(8);
    expect_out("deb_rel_hold", ObsEf, 8'h01);
    drain();
    cyc(14);
    expect_out("deb_rel_ef", ObsEf, 8'h03);
    expect_out("deb_rel_any", ObsAny, 8'h01);
    drain();

    // Two-tick glitch on pad0 key3 must never surface.
    sel_write(8'h03, 3'd2);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) key_raw[3] = 1'b1;
      if (i == 2*PS) key_raw[3] = 1'b0;
      @(negedge clk_sys);
      if (ef_n[0] !== 1'b1 || any_n !== 1'b1) bad = 1'b1;
      cyc(1);
    end
    chk("glitch_quiet", {7'd0, bad}, 8'd0);

    // Select range on pad0 key9.
    key_raw[9] = 1'b1;
    cyc(4*PS + 8);
    expect_out("k9_any", ObsAny, 8'h00);
    drain();
    sel_write(8'h0A, 3'd2);
    expect_out("selA", ObsSel, 8'h0A);
    expect_out("selA_ef", ObsEf, 8'h03);
    drain();
    sel_write(8'h09, 3'd2);
    expect_out("sel9_ef", ObsEf, 8'h02);
    drain();
    sel_write(8'h03, 3'd1);
    expect_out("wrong_port_sel", ObsSel, 8'h09);
    expect_out("wrong_port_ef", ObsEf, 8'h02);
    drain();
    key_raw[9] = 1'b0;
    cyc(4*PS + 8);

    // Sticky press on pad0 key2.
    sel_write(8'h02, 3'd2);
    expect_out("sticky_pre", ObsEfS, 8'h03);
    drain();
    key_raw[2] = 1'b1;
    cyc(4*PS + 8);
    expect_out("sticky_press", ObsEfS, 8'h02);
    expect_out("direct_press", ObsEf, 8'h02);
    drain();
    key_raw[2] = 1'b0;
    cyc(4*PS + 8);
    expect_out("sticky_held", ObsEfS, 8'h02);
    expect_out("direct_rel", ObsEf, 8'h03);
    drain();
    sel_write(8'h04, 3'd2);
    expect_out("sticky_sel4", ObsEfS, 8'h03);
    drain();
    sel_write(8'h02, 3'd2);
    expect_out("sticky_cleared", ObsEfS, 8'h03);
    expect_out("sticky_sel_s", ObsSelS, 8'h02);
    drain();

    // Reset mid-press after roughly two samples of pad0 key0.
    key_raw[0] = 1'b1;
    cyc(2*PS + 2);
    resetq = 1'b0;
    #1;
    expect_out("arst_sel", ObsSel, 8'h00);
    expect_out("arst_ef", ObsEf, 8'h03);
    expect_out("arst_any", ObsAny, 8'h01);
    expect_out("arst_sel_s", ObsSelS, 8'h00);
    drain();
    cyc(3);
    resetq = 1'b1;
    cyc(14);
    expect_out("arst_no_early", ObsEf, 8'h03);
    expect_out("arst_no_early_any", ObsAny, 8'h01);
    drain();
    wait_ef("arst_full_press", 0, 1'b0, 20);
    expect_out("arst_press_any", ObsAny, 8'h00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
